// File: rtl/approx_mult_error_monitor.sv
// Sweeps every operand pair through an exact and an approximate multiplier and
// accumulates error statistics (mismatch count, max / sum of absolute error).
module approx_mult_error_monitor #(
    parameter int OP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [OP_W-1:0]     a_out,
    output logic [OP_W-1:0]     b_out,
    input  logic [2*OP_W-1:0]   exact_in,
    input  logic [2*OP_W-1:0]   approx_in,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W:0]     err_count,
    output logic [2*OP_W-1:0]   max_abs_err,
    output logic [OP_W-1:0]     max_err_a,
    output logic [OP_W-1:0]     max_err_b,
    output logic [4*OP_W-1:0]   sum_abs_err
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // SWEEP | one operand pair presented and captured per cycle
    // DRAIN | last captured pair is accumulated
    // DONE  | statistics valid and frozen; start begins a new sweep
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam int PW = 2 * OP_W;

    state_t state, state_next;

    logic [PW-1:0] idx;
    logic [PW-1:0] idx_next;
    logic          last_pair;
    logic          sweep_start;
    logic [PW-1:0] abs_err;
    logic          neq;

    logic          stage_valid;
    logic [PW-1:0] stage_abs;
    logic          stage_neq;
    logic [OP_W-1:0] stage_a;
    logic [OP_W-1:0] stage_b;

    assign idx         = {a_out, b_out};
    assign idx_next    = idx + PW'(1);
    assign last_pair   = &idx;
    assign sweep_start = start && ((state == IDLE) || (state == DONE));
    assign abs_err     = (approx_in >= exact_in) ? (approx_in - exact_in)
                                                 : (exact_in - approx_in);
    assign neq         = (approx_in != exact_in);

    assign busy = (state == SWEEP) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SWEEP;
            SWEEP:   if (last_pair) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (start) state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    // Capture stage: the products of the pair on the operand bus this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out       <= '0;
            b_out       <= '0;
            stage_valid <= 1'b0;
            stage_abs   <= '0;
            stage_neq   <= 1'b0;
            stage_a     <= '0;
            stage_b     <= '0;
        end else if (sweep_start) begin
            a_out       <= '0;
            b_out       <= '0;
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= (state == SWEEP);
            if (state == SWEEP) begin
                stage_abs <= abs_err;
                stage_neq <= neq;
                stage_a   <= a_out;
                stage_b   <= b_out;
                if (!last_pair) begin
                    {a_out, b_out} <= idx_next;
                end
            end
        end
    end

    // Accumulation stage; strict compare keeps the earliest pair on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            max_abs_err <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
            sum_abs_err <= '0;
        end else if (sweep_start) begin
            err_count   <= '0;
            max_abs_err <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
            sum_abs_err <= '0;
        end else if (stage_valid) begin
            err_count   <= err_count + (PW+1)'(stage_neq);
            sum_abs_err <= sum_abs_err + (4*OP_W)'(stage_abs);
            if (stage_abs > max_abs_err) begin
                max_abs_err <= stage_abs;
                max_err_a   <= stage_a;
                max_err_b   <= stage_b;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Self-checking bench: a 2-bit instance exercised with several approximate
// multiplier models and an 8-bit instance with the approximate product tied off.
module tb_approx_mult_error_monitor;

    localparam int N2 = 16;
    localparam int N8 = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start2;
    logic start8;

    logic [1:0]  a2, b2, ma2, mb2;
    logic [3:0]  exact2, approx2, maxe2;
    logic [4:0]  errc2;
    logic [7:0]  sum2;
    logic        busy2, done2;

    logic [7:0]  a8, b8, ma8, mb8;
    logic [15:0] exact8, approx8, maxe8;
    logic [16:0] errc8;
    logic [31:0] sum8;
    logic        busy8, done8;

    int mode;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] errc;
        logic [3:0] maxe;
        logic [1:0] ma;
        logic [1:0] mb;
        logic [7:0] sum;
    } exp_t;

    exp_t sb[$];

    function automatic logic [3:0] approx_model(input int m, input logic [1:0] a, input logic [1:0] b);
        logic [3:0] ex;
        ex = {2'b00, a} * {2'b00, b};
        case (m)
            0:       return ex;
            1:       return ex | 4'd1;
            2:       return 4'd0;
            default: return ex - {2'b00, b};
        endcase
    endfunction

    function automatic exp_t model_stats(input int m);
        exp_t e;
        logic [3:0] ex, ap, d;
        e = '0;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                ex = 4'(ai * bi);
                ap = approx_model(m, 2'(ai), 2'(bi));
                d  = (ap >= ex) ? ap - ex : ex - ap;
                if (ap != ex) e.errc = e.errc + 5'd1;
                e.sum = e.sum + {4'd0, d};
                if (d > e.maxe) begin
                    e.maxe = d;
                    e.ma   = 2'(ai);
                    e.mb   = 2'(bi);
                end
            end
        end
        return e;
    endfunction

    assign exact2  = {2'b00, a2} * {2'b00, b2};
    assign approx2 = approx_model(mode, a2, b2);
    assign exact8  = {8'd0, a8} * {8'd0, b8};
    assign approx8 = exact8;

    approx_mult_error_monitor #(.OP_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(a2), .b_out(b2), .exact_in(exact2), .approx_in(approx2),
        .busy(busy2), .done(done2), .err_count(errc2), .max_abs_err(maxe2),
        .max_err_a(ma2), .max_err_b(mb2), .sum_abs_err(sum2)
    );

    approx_mult_error_monitor #(.OP_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a_out(a8), .b_out(b8), .exact_in(exact8), .approx_in(approx8),
        .busy(busy8), .done(done8), .err_count(errc8), .max_abs_err(maxe8),
        .max_err_a(ma8), .max_err_b(mb8), .sum_abs_err(sum8)
    );

    // Runs one 2-bit sweep; start stays high until hold_until edges after E0.
    task automatic do_sweep2(input int m, input int hold_until,
                             output int cyc, output int busy_cyc, output int seq_bad);
        int k;
        logic [3:0] exp_idx;
        mode = m;
        sb.push_back(model_stats(m));
        busy_cyc = 0;
        seq_bad  = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (!done2 && k < N2 + 8) begin
            if (busy2) busy_cyc++;
            exp_idx = (k < N2) ? 4'(k) : 4'(N2 - 1);
            if ({a2, b2} !== exp_idx) seq_bad++;
            @(negedge clk);
            if (k >= hold_until) start2 = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        start2 = 1'b0;
        cyc = k;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start2 = 1'b0;
        start8 = 1'b0;
        mode   = 0;
        #12;
        checks++;
        if ({a2, b2, busy2, done2, errc2, maxe2, ma2, mb2, sum2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2 got %h want 0", {a2, b2, busy2, done2, errc2, maxe2, ma2, mb2, sum2});
        end
        checks++;
        if ({a8, b8, busy8, done8, errc8, maxe8, ma8, mb8, sum8} !== '0) begin
            errors++;
            $display("FAIL reset_dut8 got %h want 0", {a8, b8, busy8, done8, errc8, maxe8, ma8, mb8, sum8});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep(input int m);
        int cyc, bc, sq;
        exp_t e;
        do_sweep2(m, 0, cyc, bc, sq);
        checks++;
        if (cyc !== N2 + 1) begin
            errors++;
            $display("FAIL done_latency_m%0d got %0d want %0d", m, cyc, N2 + 1);
        end
        checks++;
        if (bc !== N2 + 1) begin
            errors++;
            $display("FAIL busy_cycles_m%0d got %0d want %0d", m, bc, N2 + 1);
        end
        checks++;
        if (sq !== 0) begin
            errors++;
            $display("FAIL operand_seq_m%0d got %0d bad cycles want 0", m, sq);
        end
        e = sb.pop_front();
        checks++;
        if ({errc2, maxe2, ma2, mb2, sum2} !== e) begin
            errors++;
            $display("FAIL stats_m%0d got cnt=%0d max=%0d tag=(%0d,%0d) sum=%0d want cnt=%0d max=%0d tag=(%0d,%0d) sum=%0d",
                     m, errc2, maxe2, ma2, mb2, sum2, e.errc, e.maxe, e.ma, e.mb, e.sum);
        end
    endtask

    task automatic test_frozen;
        logic [20:0] snap;
        snap = {errc2, maxe2, ma2, mb2, sum2};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done2, busy2, a2, b2, errc2, maxe2, ma2, mb2, sum2} !== {1'b1, 1'b0, 2'b11, 2'b11, snap}) begin
            errors++;
            $display("FAIL done_frozen got %h want %h", {done2, busy2, a2, b2, errc2, maxe2, ma2, mb2, sum2},
                     {1'b1, 1'b0, 2'b11, 2'b11, snap});
        end
    endtask

    task automatic test_start_held;
        int cyc, bc, sq;
        exp_t e;
        do_sweep2(2, N2 - 2, cyc, bc, sq);
        checks++;
        if (cyc !== N2 + 1 || sq !== 0) begin
            errors++;
            $display("FAIL held_start_single_run got cyc=%0d bad=%0d want cyc=%0d bad=0", cyc, sq, N2 + 1);
        end
        e = sb.pop_front();
        checks++;
        if ({errc2, maxe2, ma2, mb2, sum2} !== e) begin
            errors++;
            $display("FAIL held_start_stats got %h want %h", {errc2, maxe2, ma2, mb2, sum2}, e);
        end
        do_sweep2(2, 0, cyc, bc, sq);
        e = sb.pop_front();
        checks++;
        if ({errc2, maxe2, ma2, mb2, sum2} !== e || cyc !== N2 + 1) begin
            errors++;
            $display("FAIL rerun_stats got %h cyc=%0d want %h cyc=%0d", {errc2, maxe2, ma2, mb2, sum2}, cyc, e, N2 + 1);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int k;
        mode = 1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!(a2 == 2'd1 && b2 == 2'd1) && k < N2 + 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if ({a2, b2} !== 4'b0101 || errc2 !== 5'd4 || sum2 !== 8'd4) begin
            errors++;
            $display("FAIL mid_sweep_state got ab=%h cnt=%0d sum=%0d want ab=5 cnt=4 sum=4", {a2, b2}, errc2, sum2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a2, b2, busy2, done2, errc2, maxe2, ma2, mb2, sum2} !== '0) begin
            errors++;
            $display("FAIL mid_sweep_reset got %h want 0", {a2, b2, busy2, done2, errc2, maxe2, ma2, mb2, sum2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_sweep(2);
    endtask

    task automatic test_tied8;
        int k, bc;
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        k  = 0;
        bc = 0;
        while (!done8 && k < N8 + 16) begin
            if (busy8) bc++;
            @(negedge clk);
            start8 = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k !== N8 + 1) begin
            errors++;
            $display("FAIL op8_done_latency got %0d want %0d", k, N8 + 1);
        end
        checks++;
        if (bc !== N8 + 1) begin
            errors++;
            $display("FAIL op8_busy_cycles got %0d want %0d", bc, N8 + 1);
        end
        checks++;
        if ({errc8, maxe8, ma8, mb8, sum8} !== '0 || {a8, b8} !== 16'hFFFF) begin
            errors++;
            $display("FAIL op8_tied_stats got cnt=%0d max=%0d tag=(%0d,%0d) sum=%0d ab=%h want all 0 ab=ffff",
                     errc8, maxe8, ma8, mb8, sum8, {a8, b8});
        end
    endtask

    initial begin
        test_reset();
        test_sweep(1);
        test_frozen();
        test_sweep(2);
        test_sweep(3);
        test_sweep(0);
        test_start_held();
        test_reset_mid_sweep();
        test_tied8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
